// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings for the RegisterFile write-back scheduler.
package regfile_ctrl_pkg;
  localparam int PC_IDX = 15;

  typedef enum logic {ARB = 1'b0, MEM_LOCKED = 1'b1} state_e;

  // Source encodings double as bit indices into req/gnt.
  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; lock_mem restricts grants to the mem source.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       lock_mem,
  output logic [1:0] gnt
);
  import regfile_ctrl_pkg::*;

  logic ptr; // 0 favours ALU, 1 favours mem

  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= gnt[SRC_ALU]; // next contest favours whoever lost this one
  end

  always_comb begin
    gnt = '0;
    if (lock_mem)   gnt[SRC_MEM] = req[SRC_MEM];
    else if (&req)  gnt = ptr ? 2'b10 : 2'b01;
    else            gnt = req;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler sharing the RegisterFile data port between ALU and loads,
// and steering R15 writes / PC increments onto the PC port.
module regfile_wb_arbiter #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int PC_IDX = regfile_ctrl_pkg::PC_IDX
) (
  input  logic          Clk,
  input  logic          RESET,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic          mem_lock,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          pc_inc_valid,
  input  logic [DW-1:0] pc_next,
  output logic          pc_inc_ack,
  output logic [DW-1:0] rf_in,
  output logic [AW-1:0] rf_rd,
  output logic          rf_load,
  output logic [DW-1:0] rf_pcin,
  output logic          rf_loadpc,
  output logic          busy
);
  import regfile_ctrl_pkg::*;

  localparam logic [AW-1:0] PC_RD = AW'(PC_IDX);

  state_e        state, state_nxt;
  logic          lock_mem;
  logic [1:0]    req, gnt;
  logic          alu_xfer, mem_xfer, xfer, r15_wr;
  logic [AW-1:0] win_rd;
  logic [DW-1:0] win_data;

  always_comb begin
    req          = '0;
    req[SRC_ALU] = alu_valid;
    req[SRC_MEM] = mem_valid;
  end

  rr_arbiter2 u_rr (
    .clk      (Clk),
    .rst_n    (RESET),
    .req      (req),
    .advance  (xfer),
    .lock_mem (lock_mem),
    .gnt      (gnt)
  );

  // Grants only go to valid requesters, so ready doubles as the transfer strobe.
  assign alu_xfer  = RESET && gnt[SRC_ALU];
  assign mem_xfer  = RESET && gnt[SRC_MEM];
  assign xfer      = alu_xfer || mem_xfer;
  assign alu_ready = alu_xfer;
  assign mem_ready = mem_xfer;

  assign win_rd     = mem_xfer ? mem_rd   : alu_rd;
  assign win_data   = mem_xfer ? mem_data : alu_data;
  assign r15_wr     = xfer && (win_rd == PC_RD);
  assign pc_inc_ack = RESET && pc_inc_valid && !r15_wr;

  always_ff @(posedge Clk) begin
    if (!RESET) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:        if (mem_xfer && mem_lock)  state_nxt = MEM_LOCKED;
      MEM_LOCKED: if (mem_xfer && !mem_lock) state_nxt = ARB;
      default:    state_nxt = ARB;
    endcase
  end

  always_comb begin
    lock_mem = (state == MEM_LOCKED);
    busy     = (state == MEM_LOCKED);
  end

  // An R15 data write takes the PC port and suppresses the increment that cycle.
  always_ff @(posedge Clk) begin
    if (!RESET) begin
      rf_in     <= '0;
      rf_rd     <= '0;
      rf_load   <= 1'b0;
      rf_pcin   <= '0;
      rf_loadpc <= 1'b0;
    end else begin
      rf_load   <= xfer && !r15_wr;
      rf_loadpc <= r15_wr || pc_inc_ack;
      if (xfer && !r15_wr) begin
        rf_rd <= win_rd;
        rf_in <= win_data;
      end
      if (r15_wr)          rf_pcin <= win_data;
      else if (pc_inc_ack) rf_pcin <= pc_next;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset sequences.
module tb_regfile_wb_arbiter;
  logic        Clk = 1'b0;
  logic        RESET;
  logic        alu_valid, mem_valid, mem_lock, pc_inc_valid;
  logic [3:0]  alu_rd, mem_rd, rf_rd;
  logic [31:0] alu_data, mem_data, pc_next, rf_in, rf_pcin;
  logic        alu_ready, mem_ready, pc_inc_ack, rf_load, rf_loadpc, busy;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter dut (
    .Clk(Clk), .RESET(RESET),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_lock(mem_lock), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .pc_inc_valid(pc_inc_valid), .pc_next(pc_next), .pc_inc_ack(pc_inc_ack),
    .rf_in(rf_in), .rf_rd(rf_rd), .rf_load(rf_load), .rf_pcin(rf_pcin),
    .rf_loadpc(rf_loadpc), .busy(busy)
  );

  typedef struct {
    logic        av;  logic [3:0] ard; logic [31:0] ad;
    logic        mv;  logic ml; logic [3:0] mrd; logic [31:0] md;
    logic        pv;  logic [31:0] pn;
    logic        ear, emr, epa;
    logic        eload; logic [3:0] erd; logic [31:0] ein;
    logic        eldpc; logic [31:0] epcin; logic ebusy;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [3:0] ard, input logic [31:0] ad,
    input logic mv, input logic ml, input logic [3:0] mrd, input logic [31:0] md,
    input logic pv, input logic [31:0] pn,
    input logic ear, input logic emr, input logic epa,
    input logic eload, input logic [3:0] erd, input logic [31:0] ein,
    input logic eldpc, input logic [31:0] epcin, input logic ebusy);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.ml = ml; v.mrd = mrd; v.md = md;
    v.pv = pv; v.pn = pn;
    v.ear = ear; v.emr = emr; v.epa = epa;
    v.eload = eload; v.erd = erd; v.ein = ein;
    v.eldpc = eldpc; v.epcin = epcin; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                       input logic mv, input logic ml, input logic [3:0] mrd,
                       input logic [31:0] md, input logic pv, input logic [31:0] pn);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_lock = ml; mem_rd = mrd; mem_data = md;
    pc_inc_valid = pv; pc_next = pn;
  endtask

  vec_t vt[18];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           av ard ad      mv ml mrd md      pv pn      ar mr pa  ld rd in      lpc pcin   busy
    vt[0]  = mk(1, 5, 32'h55,  1, 0, 6, 32'h66,  0, 0,      1, 0, 0,  1, 5, 32'h55, 0, 32'h0,   0);
    vt[1]  = mk(0, 5, 32'h55,  1, 0, 6, 32'h66,  0, 0,      0, 1, 0,  1, 6, 32'h66, 0, 32'h0,   0);
    vt[2]  = mk(1, 3, 32'hA,   1, 0, 4, 32'hB,   0, 0,      1, 0, 0,  1, 3, 32'hA,  0, 32'h0,   0);
    vt[3]  = mk(1, 3, 32'hA,   1, 0, 4, 32'hB,   0, 0,      0, 1, 0,  1, 4, 32'hB,  0, 32'h0,   0);
    vt[4]  = mk(1, 3, 32'hA,   1, 0, 4, 32'hB,   0, 0,      1, 0, 0,  1, 3, 32'hA,  0, 32'h0,   0);
    vt[5]  = mk(1, 3, 32'hA,   1, 0, 4, 32'hB,   0, 0,      0, 1, 0,  1, 4, 32'hB,  0, 32'h0,   0);
    vt[6]  = mk(1, 7, 32'h77,  0, 0, 0, 32'h0,   0, 0,      1, 0, 0,  1, 7, 32'h77, 0, 32'h0,   0);
    vt[7]  = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0,      0, 0, 0,  0, 7, 32'h77, 0, 32'h0,   0);
    vt[8]  = mk(1, 9, 32'h99,  1, 1, 1, 32'h11,  0, 0,      0, 1, 0,  1, 1, 32'h11, 0, 32'h0,   1);
    vt[9]  = mk(1, 9, 32'h99,  0, 1, 1, 32'h11,  0, 0,      0, 0, 0,  0, 1, 32'h11, 0, 32'h0,   1);
    vt[10] = mk(1, 9, 32'h99,  1, 1, 2, 32'h22,  0, 0,      0, 1, 0,  1, 2, 32'h22, 0, 32'h0,   1);
    vt[11] = mk(1, 9, 32'h99,  1, 0, 3, 32'h33,  0, 0,      0, 1, 0,  1, 3, 32'h33, 0, 32'h0,   0);
    vt[12] = mk(1, 9, 32'h99,  1, 0, 8, 32'h88,  0, 0,      1, 0, 0,  1, 9, 32'h99, 0, 32'h0,   0);
    vt[13] = mk(1, 15, 32'h100, 0, 0, 0, 32'h0,  1, 32'h44, 1, 0, 0,  0, 9, 32'h99, 1, 32'h100, 0);
    vt[14] = mk(1, 2, 32'h7,   0, 0, 0, 32'h0,   1, 32'h8,  1, 0, 1,  1, 2, 32'h7,  1, 32'h8,   0);
    vt[15] = mk(0, 0, 32'h0,   1, 0, 15, 32'h200, 1, 32'h48, 0, 1, 0, 0, 2, 32'h7,  1, 32'h200, 0);
    vt[16] = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h4C, 0, 0, 1,  0, 2, 32'h7,  1, 32'h4C,  0);
    vt[17] = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h50, 0, 0, 0,  0, 2, 32'h7,  0, 32'h4C,  0);

    // Reset with every requester asserted: nothing may be accepted.
    RESET = 1'b0;
    drive(1, 5, 32'h55, 1, 1, 6, 32'h66, 1, 32'h4);
    @(negedge Clk); @(negedge Clk);
    #1;
    chk("rst alu_ready", {31'b0, alu_ready}, 0);
    chk("rst mem_ready", {31'b0, mem_ready}, 0);
    chk("rst pc_inc_ack", {31'b0, pc_inc_ack}, 0);
    @(posedge Clk); #1;
    chk("rst rf_load", {31'b0, rf_load}, 0);
    chk("rst rf_loadpc", {31'b0, rf_loadpc}, 0);
    chk("rst rf_rd", {28'b0, rf_rd}, 0);
    chk("rst rf_in", rf_in, 0);
    chk("rst rf_pcin", rf_pcin, 0);
    chk("rst busy", {31'b0, busy}, 0);

    @(negedge Clk);
    RESET = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i != 0) @(negedge Clk);
      drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].mv, vt[i].ml, vt[i].mrd, vt[i].md,
            vt[i].pv, vt[i].pn);
      #1;
      chk($sformatf("v%0d alu_ready", i), {31'b0, alu_ready}, {31'b0, vt[i].ear});
      chk($sformatf("v%0d mem_ready", i), {31'b0, mem_ready}, {31'b0, vt[i].emr});
      chk($sformatf("v%0d pc_inc_ack", i), {31'b0, pc_inc_ack}, {31'b0, vt[i].epa});
      @(posedge Clk); #1;
      chk($sformatf("v%0d rf_load", i), {31'b0, rf_load}, {31'b0, vt[i].eload});
      chk($sformatf("v%0d rf_rd", i), {28'b0, rf_rd}, {28'b0, vt[i].erd});
      chk($sformatf("v%0d rf_in", i), rf_in, vt[i].ein);
      chk($sformatf("v%0d rf_loadpc", i), {31'b0, rf_loadpc}, {31'b0, vt[i].eldpc});
      chk($sformatf("v%0d rf_pcin", i), rf_pcin, vt[i].epcin);
      chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, vt[i].ebusy});
    end

    // Reset in the middle of a locked burst.
    @(negedge Clk);
    drive(0, 0, 32'h0, 1, 1, 5, 32'h5A, 0, 32'h0);
    #1;
    chk("mb beat mem_ready", {31'b0, mem_ready}, 1);
    @(posedge Clk); #1;
    chk("mb beat busy", {31'b0, busy}, 1);
    chk("mb beat rf_rd", {28'b0, rf_rd}, 5);
    @(negedge Clk);
    RESET = 1'b0;
    drive(1, 9, 32'h99, 1, 1, 6, 32'h6B, 1, 32'h60);
    #1;
    chk("mb rst mem_ready", {31'b0, mem_ready}, 0);
    chk("mb rst pc_inc_ack", {31'b0, pc_inc_ack}, 0);
    @(posedge Clk); #1;
    chk("mb rst busy", {31'b0, busy}, 0);
    chk("mb rst rf_load", {31'b0, rf_load}, 0);
    chk("mb rst rf_loadpc", {31'b0, rf_loadpc}, 0);
    chk("mb rst rf_rd", {28'b0, rf_rd}, 0);
    @(negedge Clk);
    RESET = 1'b1;
    drive(1, 9, 32'h99, 1, 0, 6, 32'h6B, 0, 32'h0);
    #1;
    chk("mb post alu_ready", {31'b0, alu_ready}, 1);
    chk("mb post mem_ready", {31'b0, mem_ready}, 0);
    @(posedge Clk); #1;
    chk("mb post rf_load", {31'b0, rf_load}, 1);
    chk("mb post rf_rd", {28'b0, rf_rd}, 9);
    chk("mb post rf_in", rf_in, 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
